// File: rtl/store_buffer.sv
// Store buffer: queues accumulator stores to data memory, drains them in
// push order over a write-enable/acknowledge handshake, and forwards the
// youngest pending store data to a load whose address matches.
module store_buffer #(
  parameter int DATA_WIDTH = 11,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_WIDTH-1:0]      st_addr,
  input  logic [DATA_WIDTH-1:0]      st_data,
  output logic                       mem_wr_en,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_data,
  input  logic                       mem_ack,
  input  logic [ADDR_WIDTH-1:0]      ld_addr,
  output logic                       ld_hit,
  output logic [DATA_WIDTH-1:0]      ld_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] addr_mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  logic                  empty_s;
  logic                  ready_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  ld_hit_s;
  logic [DATA_WIDTH-1:0] ld_data_s;
  logic [PTR_W-1:0]      scan_idx_s;
  logic                  match_s;

  // Handshake qualifiers; full blocks pushes even when a pop happens this cycle.
  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign ready_s = (count_r != FULL_CNT);
  assign push_s  = st_valid && ready_s;
  assign pop_s   = (!empty_s) && mem_ack;

  assign st_ready  = ready_s;
  assign empty     = empty_s;
  assign count     = count_r;
  assign mem_wr_en = !empty_s;
  assign mem_addr  = empty_s ? {ADDR_WIDTH{1'b0}} : addr_mem_r[rd_ptr_r];
  assign mem_data  = empty_s ? {DATA_WIDTH{1'b0}} : data_mem_r[rd_ptr_r];
  assign ld_hit    = ld_hit_s;
  assign ld_data   = ld_data_s;

  // Entry storage: written on push only; contents need no reset since
  // occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[wr_ptr_r] <= st_addr;
      data_mem_r[wr_ptr_r] <= st_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Forwarding scan from oldest to youngest occupied entry so the youngest
  // match overrides older ones; slots beyond the occupancy never match.
  always_comb begin
    ld_hit_s   = 1'b0;
    ld_data_s  = {DATA_WIDTH{1'b0}};
    scan_idx_s = rd_ptr_r;
    match_s    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx_s = rd_ptr_r + PTR_W'(i);
      match_s    = (CNT_W'(i) < count_r) && (addr_mem_r[scan_idx_s] == ld_addr);
      ld_hit_s   = ld_hit_s | match_s;
      ld_data_s  = match_s ? data_mem_r[scan_idx_s] : ld_data_s;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: stimulus pushes expected memory writes
// into a queue, a negedge monitor pops and compares every acknowledged write.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [10:0] st_addr;
  logic [10:0] st_data;
  logic        mem_wr_en;
  logic [10:0] mem_addr;
  logic [10:0] mem_data;
  logic        mem_ack;
  logic [10:0] ld_addr;
  logic        ld_hit;
  logic [10:0] ld_data;
  logic [2:0]  count;
  logic        empty;

  int total = 0;
  int bad   = 0;
  logic [21:0] exp_q [$];

  store_buffer #(.DATA_WIDTH(11), .ADDR_WIDTH(11), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [10:0] a, input logic [10:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    exp_q.push_back({a, d});
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    mem_ack = 1'b1;
    repeat (n) tick();
    mem_ack = 1'b0;
  endtask

  // Monitor: every acknowledged write must be the oldest expected store.
  always @(negedge clk) begin
    if (rst_n && mem_wr_en && mem_ack) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL drain_unexpected: got %0h/%0h expected none", mem_addr, mem_data);
      end else begin
        check("drain_order", {10'b0, mem_addr, mem_data}, {10'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = 11'h0; st_data = 11'h0;
    mem_ack = 1'b0; ld_addr = 11'h0;
    #3;
    check("rst_ready", st_ready, 1);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_hit", ld_hit, 0);
    check("rst_ld_data", ld_data, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Single store round trip.
    do_push(11'h005, 11'h782);
    check("t1_wr_en", mem_wr_en, 1);
    check("t1_addr", mem_addr, 11'h005);
    check("t1_data", mem_data, 11'h782);
    check("t1_count", count, 1);
    drain(1);
    check("t1_empty", empty, 1);
    check("t1_wr_en_off", mem_wr_en, 0);

    // Fill to full, ignored fifth request, then accepted after a pop.
    for (int i = 0; i < 4; i++) do_push(11'h040 + 11'(i), 11'h300 + 11'(i));
    check("t2_count_full", count, 4);
    check("t2_not_ready", st_ready, 0);
    st_valid = 1'b1; st_addr = 11'h0AA; st_data = 11'h555;
    tick();
    check("t2_ignored_count", count, 4);
    mem_ack = 1'b1;
    check("t2_full_no_push", st_ready, 0);
    tick();
    mem_ack = 1'b0;
    check("t2_after_pop_count", count, 3);
    check("t2_ready_again", st_ready, 1);
    exp_q.push_back({11'h0AA, 11'h555});
    tick();
    st_valid = 1'b0;
    check("t2_fifth_in", count, 4);
    drain(4);
    check("t2_empty", empty, 1);

    // Simultaneous push and pop at count 2.
    do_push(11'h0B0, 11'h111);
    do_push(11'h0B1, 11'h222);
    st_valid = 1'b1; st_addr = 11'h0B2; st_data = 11'h333;
    exp_q.push_back({11'h0B2, 11'h333});
    mem_ack = 1'b1;
    tick();
    st_valid = 1'b0; mem_ack = 1'b0;
    check("t3_count", count, 2);
    check("t3_head", mem_addr, 11'h0B1);
    drain(2);

    // Forwarding picks the youngest matching store.
    do_push(11'h010, 11'h2AA);
    ld_addr = 11'h010;
    #1;
    check("t4_single_hit_data", ld_data, 11'h2AA);
    do_push(11'h010, 11'h071);
    check("t4_hit", ld_hit, 1);
    check("t4_youngest", ld_data, 11'h071);
    ld_addr = 11'h011;
    #1;
    check("t4_miss", ld_hit, 0);
    ld_addr = 11'h010;
    drain(2);
    check("t4_drained_hit", ld_hit, 0);
    check("t4_drained_data", ld_data, 0);

    // Pointer wrap with interleaved acks.
    for (int i = 0; i < 6; i++) begin
      st_valid = 1'b1;
      st_addr  = 11'h100 + 11'(i);
      st_data  = 11'h600 + 11'(i);
      exp_q.push_back({11'h100 + 11'(i), 11'h600 + 11'(i)});
      mem_ack  = (i % 2 == 1);
      tick();
    end
    st_valid = 1'b0; mem_ack = 1'b0;
    check("t5_count", count, 3);
    ld_addr = 11'h102;
    #1;
    check("t5_stale_no_hit", ld_hit, 0);
    ld_addr = 11'h104;
    #1;
    check("t5_live_hit", ld_hit, 1);
    check("t5_live_data", ld_data, 11'h604);
    drain(3);
    check("t5_empty", empty, 1);

    // Asynchronous reset mid-handshake.
    do_push(11'h200, 11'h01A);
    do_push(11'h201, 11'h01B);
    do_push(11'h202, 11'h01C);
    check("t6_count3", count, 3);
    mem_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_count", count, 0);
    check("t6_rst_wr_en", mem_wr_en, 0);
    check("t6_rst_ready", st_ready, 1);
    check("t6_rst_empty", empty, 1);
    exp_q.delete();
    mem_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_push(11'h3FF, 11'h7FF);
    check("t6_post_addr", mem_addr, 11'h3FF);
    drain(1);
    check("t6_post_empty", empty, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-side counterpart of the accumulator-A load path: the load path brings ALU, extension or data-memory values into A; this block carries A's value back out to data memory.
- Buffers up to DEPTH pending stores (address + A value) issued by the control unit, so the core does not stall on memory acknowledge latency.
- Drains stores in order to data memory using a write-enable/acknowledge handshake.
- Forwards the youngest pending store data to loads whose address matches, so a load never reads stale memory.

Parameters:
- DATA_WIDTH, 11, width of the accumulator and data-memory word.
- ADDR_WIDTH, 11, data-memory address width.
- DEPTH, 4, number of store entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- st_valid  input  1  store request from the control unit.
- st_ready  output  1  buffer can accept a store this cycle.
- st_addr  input  ADDR_WIDTH  store address.
- st_data  input  DATA_WIDTH  store data (accumulator A value).
- mem_wr_en  output  1  head entry is presented to data memory.
- mem_addr  output  ADDR_WIDTH  head entry address.
- mem_data  output  DATA_WIDTH  head entry data.
- mem_ack  input  1  data memory has written the presented entry.
- ld_addr  input  ADDR_WIDTH  address of the load currently being performed.
- ld_hit  output  1  a pending store matches ld_addr.
- ld_data  output  DATA_WIDTH  data of the youngest matching pending store.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- empty  output  1  count == 0.

Behaviour:
- Storage:
  - Circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH.
  - Occupancy is held in a separate count register.
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - Entry contents are don't-care.
  - Outputs immediately: st_ready=1, mem_wr_en=0, mem_addr=0, mem_data=0, ld_hit=0, ld_data=0, count=0, empty=1.
  - Reset asserted mid-drain discards all pending entries; the memory handshake is abandoned.
- Push:
  - st_ready = (count != DEPTH), combinational.
  - Push occurs when st_valid && st_ready at a rising edge.
  - On push, the entry at wr_ptr is written with {st_addr, st_data} and wr_ptr increments.
  - st_valid while full is ignored: no write, no error. The control unit holds st_valid until st_ready.
- Drain:
  - mem_wr_en = !empty, combinational.
  - mem_addr and mem_data show the entry at rd_ptr whenever not empty; both are 0 when empty.
  - Pop occurs when mem_wr_en && mem_ack at a rising edge; rd_ptr increments.
  - mem_ack while empty is ignored.
  - Minimum latency from a push into an empty buffer to mem_wr_en is 1 cycle. There is no same-cycle bypass.
- Simultaneous push and pop:
  - Both happen and count is unchanged.
  - When full, st_ready is 0, so no push occurs even if a pop happens in the same cycle.
  - When empty, no pop occurs, so the push alone happens.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. It is never above DEPTH or below 0.
- Forwarding (combinational):
  - Scan all occupied entries.
  - ld_hit = 1 if any occupied entry address equals ld_addr.
  - ld_data = data of the matching entry closest to wr_ptr, i.e. the youngest.
  - ld_data = 0 when there is no hit.
  - Unoccupied slots never hit, even if they hold stale matching addresses.
  - A store being pushed in the same cycle is not visible to forwarding until the next cycle.
  - An entry popping this cycle is still visible this cycle.
- Ordering: memory writes leave in exact push order, including repeated writes to the same address.

Test Plan:
- Reset, then push {addr=0x005, data=0x782} → next cycle mem_wr_en=1, mem_addr=0x005, mem_data=0x782, count=1; pulse mem_ack → empty=1, mem_wr_en=0.
- Push 4 stores with mem_ack=0 → count=4, st_ready=0; a 5th st_valid is ignored; ack one → st_ready=1 and the 5th is accepted on the next edge; drain order matches push order.
- At count=2, assert st_valid and mem_ack in the same cycle → count stays 2, next head is the 2nd store.
- Push 0x010→0x2AA, then 0x010→0x071; set ld_addr=0x010 → ld_hit=1, ld_data=0x071; after both drain → ld_hit=0, ld_data=0.
- Push 6 stores with interleaved acks to force pointer wrap → memory sees all 6 in order; a stale slot address matching ld_addr gives ld_hit=0.
- Drop rst_n asynchronously with count=3 mid-handshake → immediately count=0, mem_wr_en=0, st_ready=1; after release a new push is drained correctly.
